// File: rtl/npu_dot_pkg.sv
// Shared types and width helpers for the NPU dot-product accumulate tree.
package npu_dot_pkg;

  // Operand sign mode: MODE_<data><para>, U = unsigned, S = signed.
  typedef enum logic [1:0] {
    MODE_UU = 2'b00,
    MODE_US = 2'b01,
    MODE_SU = 2'b10,
    MODE_SS = 2'b11
  } dot_mode_e;

  // Product width: two (DW+1)-bit signed operands.
  function automatic int unsigned pw(input int unsigned dw);
    return 2 * dw + 2;
  endfunction

  // Tree sum width: product width plus one bit per reduction level.
  function automatic int unsigned tw(input int unsigned lanes, input int unsigned dw);
    return pw(dw) + $clog2(lanes);
  endfunction

  // Largest signed value of an acc_w-bit accumulator (acc_w <= 64).
  function automatic logic [63:0] acc_max(input int unsigned acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

  // Smallest signed value; callers truncate to acc_w bits.
  function automatic logic [63:0] acc_min(input int unsigned acc_w);
    return ~acc_max(acc_w);
  endfunction

endpackage

// File: rtl/npu_add_tree.sv
// Combinational N-input signed adder tree; output grows by log2(N) bits.
module npu_add_tree #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 18
) (
  input  logic [N*W-1:0]                 operands_i,
  output logic signed [W+$clog2(N)-1:0]  sum_o
);

  localparam int unsigned Lv = $clog2(N);
  localparam int unsigned OW = W + Lv;

  // Level 0 holds the sign-extended operands; each level halves the node count.
  for (genvar l = 0; l <= Lv; l++) begin : g_lvl
    localparam int unsigned Cnt = N >> l;
    logic signed [OW-1:0] v [Cnt];
    for (genvar i = 0; i < Cnt; i++) begin : g_n
      if (l == 0) begin : g_leaf
        assign v[i] = {{(OW - W){operands_i[i*W + W - 1]}}, operands_i[i*W +: W]};
      end else begin : g_add
        assign v[i] = g_lvl[l-1].v[2*i] + g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign sum_o = g_lvl[Lv].v[0];

endmodule

// File: rtl/npu_dot_acc_tree.sv
// Pipelined LANES-wide dot product with multi-beat accumulation and overflow handling.
// S1: products, S2: tree sum, S3: accumulator and output register.
module npu_dot_acc_tree
  import npu_dot_pkg::*;
#(
  parameter int unsigned LANES = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 32,
  parameter bit          SAT   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DW-1:0]      in_data,
  input  logic [LANES*DW-1:0]      in_para,
  input  logic                     in_data_signed,
  input  logic                     in_para_signed,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_result,
  output logic                     out_ovf
);

  localparam int unsigned PW = pw(DW);
  localparam int unsigned TW = tw(LANES, DW);
  localparam logic [ACC_W-1:0] AccMax = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] AccMin = ACC_W'(acc_min(ACC_W));

  logic en;
  dot_mode_e in_mode;
  logic data_sgn, para_sgn;
  logic [LANES*PW-1:0] prod;
  logic signed [TW-1:0] tree_sum;

  logic                 s1_valid_d, s1_valid_q, s1_first_d, s1_first_q, s1_last_d, s1_last_q;
  logic [LANES*PW-1:0]  s1_prod_d, s1_prod_q;
  logic                 s2_valid_d, s2_valid_q, s2_first_d, s2_first_q, s2_last_d, s2_last_q;
  logic signed [TW-1:0] s2_sum_d, s2_sum_q;
  logic [ACC_W-1:0]     acc_d, acc_q;
  logic                 ovf_d, ovf_q, group_done_d, group_done_q;
  logic                 out_valid_d, out_valid_q, out_ovf_d, out_ovf_q;
  logic [ACC_W-1:0]     out_result_d, out_result_q;

  logic                 grp_start;
  logic [ACC_W-1:0]     sum_ext, acc_base, acc_next;
  logic [ACC_W:0]       add_full;
  logic                 add_ovf, ovf_next;

  // The whole pipeline advances only when the output register can take a new value.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign in_mode  = dot_mode_e'({in_data_signed, in_para_signed});
  assign data_sgn = (in_mode == MODE_SU) || (in_mode == MODE_SS);
  assign para_sgn = (in_mode == MODE_US) || (in_mode == MODE_SS);

  // Per-lane multiply of sign- or zero-extended operands.
  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      logic signed [DW:0]   a, b;
      logic signed [PW-1:0] p;
      a = {data_sgn & in_data[i*DW + DW - 1], in_data[i*DW +: DW]};
      b = {para_sgn & in_para[i*DW + DW - 1], in_para[i*DW +: DW]};
      p = PW'(a) * PW'(b);
      prod[i*PW +: PW] = p;
    end
  end

  npu_add_tree #(
    .N (LANES),
    .W (PW)
  ) u_tree (
    .operands_i (s1_prod_q),
    .sum_o      (tree_sum)
  );

  // Next state for the product and tree-sum stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_prod_d  = s1_prod_q;
    s2_valid_d = s2_valid_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    s2_sum_d   = s2_sum_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_first_d = in_first;
      s1_last_d  = in_last;
      s1_prod_d  = prod;
      s2_valid_d = s1_valid_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_sum_d   = tree_sum;
    end
  end

  // Accumulate with signed overflow detection; a new group restarts from the beat sum.
  always_comb begin
    grp_start = s2_first_q || group_done_q;
    sum_ext   = ACC_W'(s2_sum_q);
    acc_base  = grp_start ? '0 : acc_q;
    add_full  = {acc_base[ACC_W-1], acc_base} + {sum_ext[ACC_W-1], sum_ext};
    add_ovf   = add_full[ACC_W] != add_full[ACC_W-1];
    acc_next  = add_full[ACC_W-1:0];
    if (add_ovf && SAT) begin
      acc_next = add_full[ACC_W] ? AccMin : AccMax;
    end
    ovf_next = (!grp_start && ovf_q) || add_ovf;
  end

  // Accumulator and output register next state; bubbles leave acc untouched.
  always_comb begin
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    group_done_d = group_done_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    if (en) begin
      out_valid_d = s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        acc_d        = acc_next;
        ovf_d        = ovf_next;
        group_done_d = s2_last_q;
        if (s2_last_q) begin
          out_result_d = acc_next;
          out_ovf_d    = ovf_next;
        end
      end
    end
  end

  // Pipeline state; group_done resets high so the first beat after reset opens a group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_prod_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_first_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_sum_q     <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      group_done_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      s1_prod_q    <= s1_prod_d;
      s2_valid_q   <= s2_valid_d;
      s2_first_q   <= s2_first_d;
      s2_last_q    <= s2_last_d;
      s2_sum_q     <= s2_sum_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      group_done_q <= group_done_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;

endmodule
